pipeline_div_sequencer: RTL and testbench

Iterative RV64M divide/remainder sequencer for the 6-stage pipeline, sitting beside the EXA stage ALU. It accepts one DIV/DIVU/REM/REMU (and W-variant) operation from the EXB-stage outputs and runs a radix-2 restoring division, one quotient bit per cycle. While it runs, it holds the pipeline with `stall_req`, then presents a single-cycle result for the EXA register to capture.

---
 rtl/pipeline_div_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pipeline_div_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_div_sequencer
// Brief    : Iterative radix-2 restoring RV64M divide/remainder unit (incl. W ops)
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_div_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [1:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic            w_signed, w_sign_a, w_sign_b, w_div0, w_ovf, w_accept;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_sx, w_a_mag, w_b_mag, w_min, w_spec_res;
    logic [XLEN+1:0] w_trial;
    logic [XLEN-1:0] w_q_abs, w_r_abs, w_q_fin, w_r_fin, w_sel;

    // Operand conditioning: word operands are extended to 64 bits first so the
    // magnitude and special-case logic is shared with the full-width path.
    always_comb begin
        w_signed = ~op[0];
        w_a_sx   = is_word ? {{32{src_a[31]}}, src_a[31:0]} : src_a;
        w_a_ext  = is_word ? (w_signed ? {{32{src_a[31]}}, src_a[31:0]} : {32'b0, src_a[31:0]}) : src_a;
        w_b_ext  = is_word ? (w_signed ? {{32{src_b[31]}}, src_b[31:0]} : {32'b0, src_b[31:0]}) : src_b;
        w_sign_a = w_signed & w_a_ext[XLEN-1];
        w_sign_b = w_signed & w_b_ext[XLEN-1];
        w_a_mag  = w_sign_a ? -w_a_ext : w_a_ext;
        w_b_mag  = w_sign_b ? -w_b_ext : w_b_ext;
        w_min    = is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        w_div0   = (w_b_ext == '0);
        w_ovf    = w_signed && (w_a_ext == w_min) && (w_b_ext == '1);
        if (op[1])
            w_spec_res = w_div0 ? w_a_sx : '0;
        else
            w_spec_res = w_div0 ? '1 : w_a_sx;
        w_accept = start && !flush;
    end

    always_comb begin
        w_trial = {1'b0, rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
        w_q_abs = word_q ? {32'b0, quo_q[31:0]} : quo_q;
        w_r_abs = word_q ? {32'b0, rem_q[31:0]} : rem_q;
        w_q_fin = negq_q ? -w_q_abs : w_q_abs;
        w_r_fin = negr_q ? -w_r_abs : w_r_abs;
        w_sel   = op_q[1] ? w_r_fin : w_q_fin;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        op_d     = op_q;
        word_d   = word_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        rd_d     = rd_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d   = op;
                    word_d = is_word;
                    rd_d   = rd_in;
                    negq_d = w_sign_a ^ w_sign_b;
                    negr_d = w_sign_a;
                    if (w_div0 || w_ovf) begin
                        result_d = w_spec_res;
                        state_d  = S_DONE;
                    end else begin
                        // Word dividend sits in the top half so 32 shifts suffice.
                        quo_d   = is_word ? {w_a_mag[31:0], 32'b0} : w_a_mag;
                        rem_d   = '0;
                        dvs_d   = w_b_mag;
                        cnt_d   = is_word ? 7'd32 : 7'd64;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!w_trial[XLEN+1]) begin
                        rem_d = w_trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1)
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = word_q ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            op_q     <= op_d;
            word_q   <= word_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign stall_req    = reset && (((state_q == S_IDLE) && w_accept) ||
                                    (state_q == S_BUSY) || (state_q == S_FIX));
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign rd_out       = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_div_sequencer
// Brief    : Self-checking bench with an arithmetic reference model for the divider
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        is_word;
    logic [63:0] src_a, src_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_req, busy, result_valid;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [63:0] last_result = '0;

    always #5 clk = ~clk;

    pipeline_div_sequencer #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .is_word(is_word),
        .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .flush(flush),
        .stall_req(stall_req), .busy(busy), .result_valid(result_valid),
        .result(result), .rd_out(rd_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Division by zero and signed overflow bypass the iteration.
    function automatic bit is_special(input logic [1:0] o, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        bit sgn = !o[0];
        if (w)
            return (b[31:0] == 0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        bit          sgn = !o[0];
        logic [31:0] a32, b32, q32, r32, s32;
        logic [63:0] q, r;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin
                q32 = '1; r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            s32 = o[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        if (b == 0) begin
            q = '1; r = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a; r = 0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return o[1] ? r : q;
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom % 7)
            0: v = 64'd0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'($urandom % 20);
            4: v = {$urandom, 32'h8000_0000};
            5: v = {32'($urandom), 32'($urandom % 1000)};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Runs one operation cycle by cycle; abort_k >= 0 injects flush (or reset)
    // in that cycle of the operation instead of letting it complete.
    task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int abort_k, input bit use_reset);
        logic [4:0]  rd  = 5'($urandom);
        logic [63:0] exp = model(o, w, a, b);
        int          lat = is_special(o, w, a, b) ? 1 : (w ? 34 : 66);
        for (int k = 0; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                start = 1'b1; op = o; is_word = w; src_a = a; src_b = b; rd_in = rd;
            end else begin
                start = 1'($urandom); op = 2'($urandom); is_word = 1'($urandom);
                src_a = {$urandom, $urandom}; src_b = {$urandom, $urandom}; rd_in = 5'($urandom);
            end
            if (k == abort_k && !use_reset) begin
                flush = 1'b1;
                @(negedge clk);
                chk("stall_in_flush", {63'b0, stall_req}, 64'd1);
                @(posedge clk); #1;
                flush = 1'b0; start = 1'b0;
                @(negedge clk);
                chk("busy_after_flush", {63'b0, busy}, 64'd0);
                chk("valid_after_flush", {63'b0, result_valid}, 64'd0);
                chk("stall_after_flush", {63'b0, stall_req}, 64'd0);
                chk("result_after_flush", result, last_result);
                return;
            end
            if (k == abort_k && use_reset) begin
                start = 1'b1;
                #1 reset = 1'b0;
                #1;
                chk("rst_busy", {63'b0, busy}, 64'd0);
                chk("rst_stall", {63'b0, stall_req}, 64'd0);
                chk("rst_valid", {63'b0, result_valid}, 64'd0);
                chk("rst_result", result, 64'd0);
                chk("rst_rd_out", {59'b0, rd_out}, 64'd0);
                @(posedge clk); @(posedge clk); #1;
                start = 1'b0; reset = 1'b1;
                last_result = '0;
                return;
            end
            @(negedge clk);
            chk("stall_req", {63'b0, stall_req}, {63'b0, k < lat});
            chk("result_valid", {63'b0, result_valid}, {63'b0, k == lat});
            chk("busy", {63'b0, busy}, {63'b0, k > 0});
            if (k == lat) begin
                chk("result", result, exp);
                chk("rd_out", {59'b0, rd_out}, {59'b0, rd});
                last_result = exp;
            end else begin
                chk("result_hold", result, last_result);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = '0; is_word = 1'b0;
        src_a = '0; src_b = '0; rd_in = '0; flush = 1'b0;

        chk("pin_divu", model(2'b01, 1'b0, 64'd100, 64'd7), 64'd14);
        chk("pin_rem", model(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("pin_div", model(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7), 64'hFFFF_FFFF_FFFF_FFF2);
        chk("pin_divw", model(2'b00, 1'b1, 64'h1234_5678_FFFF_FFF0, 64'd3), 64'hFFFF_FFFF_FFFF_FFFB);
        chk("pin_divuw", model(2'b01, 1'b1, 64'hFFFF_FFFF, 64'd1), '1);
        chk("pin_ovf", model(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1), 64'h8000_0000_0000_0000);

        #2;
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_valid", {63'b0, result_valid}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_rd_out", {59'b0, rd_out}, 64'd0);
        chk("reset_stall", {63'b0, stall_req}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        run_op(2'b01, 1'b0, 64'd100, 64'd7, -1, 1'b0);
        run_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, -1, 1'b0);
        run_op(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, -1, 1'b0);
        run_op(2'b01, 1'b0, 64'd55, 64'd0, -1, 1'b0);
        run_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, -1, 1'b0);
        run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, -1, 1'b0);
        run_op(2'b00, 1'b1, 64'h1234_5678_FFFF_FFF0, 64'd3, -1, 1'b0);
        run_op(2'b01, 1'b1, 64'hFFFF_FFFF, 64'd1, -1, 1'b0);
        run_op(2'b11, 1'b1, 64'h0000_0000_8000_0005, 64'd0, -1, 1'b0);

        // Flush at T20, then a new op in the very next cycle.
        run_op(2'b01, 1'b0, {$urandom, $urandom}, 64'd13, 20, 1'b0);
        run_op(2'b01, 1'b0, 64'd9, 64'd3, -1, 1'b0);

        // Flush in IDLE suppresses a start.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", {63'b0, stall_req}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", {63'b0, busy}, 64'd0);

        run_op(2'b00, 1'b0, 64'd1000, 64'd9, 10, 1'b1);
        run_op(2'b10, 1'b0, 64'd1000, 64'd9, -1, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op(2'($urandom), 1'($urandom), pick(), pick(), -1, 1'b0);

        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
